// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Two-requester round-robin arbiter in front of a small bitwise ALU.
//   A granted operation is captured in IDLE, evaluated in EXEC and held
//   in OUT until the consumer takes it (one op per 3 cycles at best).
//
// Ports
//   clk                      single clock, rising edge
//   rst_n                    asynchronous active-low reset
//   reqN_valid / reqN_ready  requester N handshake (ready is combinational,
//                            high only in IDLE for the granted requester)
//   reqN_op                  00 AND, 01 OR, 10 XOR, 11 NOT a
//   reqN_a / reqN_b          operands, WIDTH bits
//   res_valid / res_ready    result handshake
//   res_data / res_id        registered result and the requester owning it
//   stall_cnt                (only with ALU_ARB_STALL_CNT_EN) saturating count
//                            of cycles with res_valid && !res_ready
//
// Optional feature macro: ALU_ARB_STALL_CNT_EN
module alu_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id
`ifdef ALU_ARB_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, OUT} state_t;

  state_t           state, state_nxt;
  logic             ptr;      // requester that wins the next contention
  logic             grant0, grant1;
  logic [1:0]       op_p0;
  logic [WIDTH-1:0] a_p0, b_p0;
  logic             id_p0;

  function automatic logic [WIDTH-1:0] alu_calc(input logic [1:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~a;
    endcase
  endfunction

`ifdef ALU_ARB_STALL_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  // Grants are gated by rst_n so both readies drop the instant reset asserts.
  always_comb begin
    state_nxt = state;
    grant0    = 1'b0;
    grant1    = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n) begin
          grant0 = req0_valid && (!req1_valid || !ptr);
          grant1 = req1_valid && !grant0;
          if (grant0 || grant1) state_nxt = EXEC;
        end
      end
      EXEC:    state_nxt = OUT;
      OUT:     if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Capture stage: operands of the granted requester
  always_ff @(posedge clk) begin
    if (grant0 || grant1) begin
      op_p0 <= grant1 ? req1_op : req0_op;
      a_p0  <= grant1 ? req1_a  : req0_a;
      b_p0  <= grant1 ? req1_b  : req0_b;
      id_p0 <= grant1;
    end
  end

  // Result stage; the pointer only moves when both requesters competed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= 1'b0;
    end else begin
      if (grant0 && req1_valid) ptr <= 1'b1;
      if (grant1 && req0_valid) ptr <= 1'b0;
      if (state == EXEC) begin
        res_data  <= alu_calc(op_p0, a_p0, b_p0);
        res_id    <= id_p0;
        res_valid <= 1'b1;
      end else if (state == OUT && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_ARB_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       stall_cnt <= 16'd0;
    else if (res_valid && !res_ready) stall_cnt <= sat_inc(stall_cnt);
  end
`endif

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports req0_valid/req1_valid  input  1  requester N presents an operation.
REQ-005 SHALL have ports req0_ready/req1_ready  output  1  requester N's operation accepted this cycle.
REQ-006 SHALL have ports req0_op/req1_op  input  2  op select: 00 AND, 01 OR, 10 XOR, 11 NOT a.
REQ-007 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  WIDTH  operands.
REQ-008 SHALL have port res_valid  output  1  result available.
REQ-009 SHALL have port res_ready  input  1  consumer accepts result.
REQ-010 SHALL have port res_data  output  WIDTH  registered result.
REQ-011 SHALL have port res_id  output  1  requester that owns res_data.

Function
REQ-012 SHALL implement FSM states IDLE, EXEC, OUT.
REQ-013 IDLE: if any reqN_valid, SHALL grant one requester, assert its reqN_ready combinationally in that cycle, capture op/a/b/id, go to EXEC.
REQ-014 Only one reqN_ready SHALL be high per cycle; both SHALL be low outside IDLE.
REQ-015 Single valid requester SHALL be granted regardless of priority pointer.
REQ-016 Both valid: SHALL grant the requester named by round-robin pointer; pointer SHALL then point to the other requester.
REQ-017 EXEC: SHALL compute captured op bitwise on full WIDTH, register into res_data/res_id, set res_valid, go to OUT.
REQ-018 NOT a SHALL ignore operand b.
REQ-019 OUT: res_valid, res_data, res_id SHALL hold stable until res_valid && res_ready; then res_valid SHALL clear next edge, state to IDLE.
REQ-020 Latency: accept on edge N, res_valid high after edge N+1 (one EXEC cycle); min throughput one op per 3 cycles.
REQ-021 reqN_valid deasserted while not granted SHALL have no effect; no request SHALL be lost once ready was asserted.
REQ-022 res_ready high in IDLE/EXEC SHALL be ignored.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, res_valid 0, res_data 0, res_id 0, pointer to requester 0, both reqN_ready 0.
REQ-024 Reset during EXEC/OUT SHALL discard the in-flight operation; no result SHALL be emitted for it.
REQ-025 First grant after reset release SHALL favour requester 0 on contention.

Configuration
REQ-026 With ALU_ARB_STALL_CNT_EN defined, SHALL add output stall_cnt (16 bits) counting cycles with res_valid && !res_ready, saturating at 0xFFFF, cleared only by reset.
REQ-027 Without ALU_ARB_STALL_CNT_EN, stall_cnt port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-028 Req0 only, op=01, a=0x0E05, b=0x667B, res_ready=1 -> req0_ready 1 cycle; res_data=0x6E7F, res_id=0 two edges later.
REQ-029 Both valid same cycle after reset, req0 AND 0x0E05/0x667B, req1 XOR same -> req0 first (0x0601, id 0), then req1 (0x687E, id 1).
REQ-030 Req1 op=11, a=0x0E05, b=0xFFFF, res_ready=0 for 5 cycles -> res_data=0xF1FA held stable, no new grant; stall_cnt=5 when macro defined.
REQ-031 Both requesters continuously valid for 4 ops -> grants alternate 0,1,0,1.
REQ-032 rst_n low during EXEC -> res_valid stays 0, no result emitted; next contended grant goes to req0.
